// File: rtl/register_pkg.sv
// Shared defaults for the register pipe and its stages.
package register_pkg;

  localparam int REG_WIDTH_DEFAULT = 16;
  localparam int REG_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/register_pipe_stage.sv
// One pipe stage: a data word, its valid bit and the stage's ready logic.
// A word that leaves without a replacement clears the data so an empty stage reads as 0.
module register_pipe_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready_s, accept_s, leave_s;

  always_comb begin
    ready_s  = ~valid_q | down_ready;
    accept_s = up_valid & ready_s & ~flush;
    leave_s  = valid_q & down_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = {WIDTH{1'b0}};
    end else if (accept_s) begin
      valid_d = 1'b1;
      data_d  = up_data;
    end else if (leave_s) begin
      valid_d = 1'b0;
      data_d  = {WIDTH{1'b0}};
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/register_pipe.sv
// Elastic DEPTH-stage register pipe with valid/ready handshake and flush.
// Define REGISTER_PIPE_COUNT_EN to add the registered occupancy output 'count'.
module register_pipe
  import register_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEFAULT,
  parameter int DEPTH = REG_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush
`ifdef REGISTER_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  logic [DEPTH-1:0]            valid_s, up_valid_s, down_ready_s;
  logic [DEPTH-1:0][WIDTH-1:0] data_s, up_data_s;

  // A stage may drain when everything downstream of it is not full, or the output is taken;
  // written as a closed form over valid bits so no ready chain loops through one vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign up_valid_s[k] = in_valid;
      assign up_data_s[k]  = in_data;
    end else begin : g_mid
      assign up_valid_s[k] = valid_s[k-1];
      assign up_data_s[k]  = data_s[k-1];
    end

    if (k == DEPTH-1) begin : g_last
      assign down_ready_s[k] = out_ready;
    end else begin : g_inner
      assign down_ready_s[k] = out_ready | ~(&valid_s[DEPTH-1:k+1]);
    end

    register_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .up_valid  (up_valid_s[k]),
      .up_data   (up_data_s[k]),
      .down_ready(down_ready_s[k]),
      .valid     (valid_s[k]),
      .data      (data_s[k])
    );
  end

  assign in_ready  = (~valid_s[0] | down_ready_s[0]) & ~flush;
  assign out_valid = valid_s[DEPTH-1];
  assign out_data  = data_s[DEPTH-1];

`ifdef REGISTER_PIPE_COUNT_EN
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             in_fire_s, out_fire_s;

  always_comb begin
    in_fire_s  = in_valid & in_ready;
    out_fire_s = out_valid & out_ready;
    count_d    = count_q;
    if (flush) begin
      count_d = {CNT_W{1'b0}};
    end else begin
      case ({in_fire_s, out_fire_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_register_pipe.sv
// Bench for register_pipe (WIDTH=16, DEPTH=3): vector table, directed corner sequences,
// then random traffic against a queue-of-words model. Count checks need REGISTER_PIPE_COUNT_EN.
module tb_register_pipe;

  localparam int WIDTH = 16;
  localparam int DEPTH = 3;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
`ifdef REGISTER_PIPE_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] count;
`endif

  int errors = 0;
  int checks = 0;

  register_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .flush    (flush),
`ifdef REGISTER_PIPE_COUNT_EN
    .count    (count),
`endif
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_rdy;
    int          e_cnt;
  } vec_t;

  vec_t tbl [13];

  // Model: words in arrival order with the stage index each one occupies.
  logic [15:0] mq_data[$];
  int          mq_pos[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_count(input string name, input int exp);
`ifdef REGISTER_PIPE_COUNT_EN
    chk(name, 32'(count), 32'(exp));
`else
    if (exp < 0) $display("count %s unused", name);
`endif
  endtask

  task automatic apply(input logic r, input logic f, input logic v,
                       input logic [15:0] d, input logic o);
    @(negedge clk);
    reset     = r;
    flush     = f;
    in_valid  = v;
    in_data   = d;
    out_ready = o;
    #1;
  endtask

  // Advance the model across one rising edge given the inputs held this cycle.
  task automatic model_step(input logic r, input logic f, input logic v,
                            input logic o, input logic [15:0] d);
    logic accept;
    int   lim;
    if (!r || f) begin
      mq_data.delete();
      mq_pos.delete();
    end else begin
      accept = v && ((mq_data.size() < DEPTH) || o);
      if (mq_data.size() > 0 && mq_pos[0] == DEPTH-1 && o) begin
        void'(mq_data.pop_front());
        void'(mq_pos.pop_front());
      end
      for (int i = 0; i < mq_pos.size(); i++) begin
        lim = (i == 0) ? DEPTH-1 : mq_pos[i-1] - 1;
        if (mq_pos[i] < lim) mq_pos[i] = mq_pos[i] + 1;
      end
      if (accept) begin
        mq_data.push_back(d);
        mq_pos.push_back(0);
      end
    end
  endtask

  initial begin : main
    logic        r, f, v, o;
    logic [15:0] d;
    logic        e_ov;
    logic [15:0] e_od;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;

    //            rst   fl    iv    data      ordy  e_ov  e_od      e_rdy e_cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'hF00F, 1'b1, 1'b0, 16'h0000, 1'b1, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hF00F, 1'b1, 1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h00F0, 1'b0, 1'b0, 16'h0000, 1'b1, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000, 1'b1, 1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'h0F00, 1'b0, 1'b0, 16'h0000, 1'b1, 2};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h00F0, 1'b0, 3};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h00F0, 1'b1, 3};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hF000, 1'b1, 2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0F00, 1'b1, 1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 0};

    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Latency and full-pipe backpressure vectors.
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk_count($sformatf("tbl%0d_count", i), tbl[i].e_cnt);
    end

    // Back-to-back stream 1..6 with no gaps.
    for (int c = 0; c < 9; c++) begin
      apply(1'b1, 1'b0, (c < 6) ? 1'b1 : 1'b0, 16'(c + 1), 1'b1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_out_valid", 32'(out_valid), (c >= 3) ? 32'd1 : 32'd0);
      chk("stream_out_data", 32'(out_data), (c >= 3) ? 32'(c - 2) : 32'd0);
    end

    // Full pipe with simultaneous in and out.
    for (int c = 0; c < 3; c++) apply(1'b1, 1'b0, 1'b1, 16'(16'h00A0 + c), 1'b0);
    for (int c = 0; c < 4; c++) begin
      apply(1'b1, 1'b0, 1'b1, 16'(16'h00B0 + c), 1'b1);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      chk("full_out_data", 32'(out_data), (c < 3) ? 32'(16'h00A0 + c) : 32'h00B0);
      chk("full_in_ready", 32'(in_ready), 32'd1);
      chk_count("full_count", 3);
    end
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("drain_out_data", 32'(out_data), 32'(16'h00B1 + c));
    end

    // Flush with two words in flight.
    apply(1'b1, 1'b0, 1'b1, 16'h00C1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 16'h00C2, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 16'hDEAD, 1'b0);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("postflush_out_valid", 32'(out_valid), 32'd0);
      chk("postflush_out_data", 32'(out_data), 32'd0);
      chk_count("postflush_count", 0);
    end

    // Reset mid-stream.
    apply(1'b1, 1'b0, 1'b1, 16'h00E1, 1'b1);
    apply(1'b1, 1'b0, 1'b1, 16'h00E2, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 16'h00E3, 1'b1);
    for (int c = 0; c < 4; c++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("postrst_out_valid", 32'(out_valid), 32'd0);
      chk("postrst_out_data", 32'(out_data), 32'd0);
      chk("postrst_in_ready", 32'(in_ready), 32'd1);
      chk_count("postrst_count", 0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      r = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      f = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      d = 16'($urandom);
      apply(r, f, v, d, o);
      if (c > 0) begin
        e_ov = (mq_data.size() > 0) && (mq_pos[0] == DEPTH-1);
        e_od = e_ov ? mq_data[0] : 16'h0000;
        chk("rnd_out_valid", 32'(out_valid), 32'(e_ov));
        chk("rnd_out_data", 32'(out_data), 32'(e_od));
        chk("rnd_in_ready", 32'(in_ready),
            32'((!f) && ((mq_data.size() < DEPTH) || o)));
        chk_count("rnd_count", mq_data.size());
      end
      model_step(r, f, v, o, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_pipe.md
REGISTER_PIPE -- requirements
Module: register_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have port clk  input  1  the one clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 SHALL have port in_data  input  WIDTH  upstream data word.
REQ-006 SHALL have port in_valid  input  1  upstream word present.
REQ-007 SHALL have port in_ready  output  1  pipe accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  WIDTH  data held in the last stage.
REQ-009 SHALL have port out_valid  output  1  last stage holds a valid word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port flush  input  1  synchronous discard of all held words.

Function
REQ-012 SHALL contain DEPTH stages; each stage holds one WIDTH-bit data word and one valid bit.
REQ-013 Transfer rule: a word moves on a rising edge when the source is valid and the sink is ready; in = in_valid&in_ready, out = out_valid&out_ready.
REQ-014 Stage k SHALL be ready when it is empty or its word leaves this cycle. The last stage leaves on out_ready; stage k<DEPTH-1 leaves into stage k+1.
REQ-015 in_ready SHALL equal stage-0 ready, and SHALL be forced to 0 while flush=1. Ready is combinational from out_ready, with no combinational path from in_valid.
REQ-016 Unstalled latency SHALL be exactly DEPTH cycles from the in transfer to out_valid=1 carrying the same word.
REQ-017 Unstalled throughput SHALL be one word per cycle; bubbles SHALL collapse: an empty stage SHALL accept even when downstream is stalled.
REQ-018 Word order SHALL be preserved; no word is duplicated or dropped, except by flush.
REQ-019 A stage whose word does not leave SHALL hold its data and valid unchanged.
REQ-020 out_data SHALL be 0 whenever out_valid=0.
REQ-021 Flush: on a rising edge with flush=1 and reset=1, all valid bits SHALL become 0. No input is accepted that cycle. An out transfer that same cycle is still counted as delivered.
REQ-022 Full pipe (all stages valid) with out_ready=0 SHALL give in_ready=0. Full pipe with out_ready=1 SHALL give in_ready=1, for simultaneous in and out.

Reset
REQ-023 reset=0 at a rising edge SHALL clear all valid bits and all data registers to 0.
REQ-024 Reset SHALL take priority over flush and transfers. A word mid-pipe at reset is discarded.
REQ-025 After reset: out_valid=0, out_data=0, in_ready=1 (if flush=0), count=0.

Configuration
REQ-026 Macro REGISTER_PIPE_COUNT_EN defined: SHALL add output count, width $clog2(DEPTH+1), giving the number of valid stages.
REQ-027 count SHALL be registered and updated as +1 on in only, -1 on out only, unchanged on both. Flush sets it to 0, or to 0 after the out adjustment. It never wraps.
REQ-028 Macro undefined: no count port and no count logic; all other behaviour identical.

Structure
REQ-029 A shared package register_pkg SHALL hold defaults REG_WIDTH_DEFAULT=16 and REG_DEPTH_DEFAULT=4.
REQ-030 Sub-module register_pipe_stage (one data+valid stage with its ready logic) SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=16, DEPTH=3)
REQ-031 Reset, then in_valid=1 with 16'hF00F, out_ready=1 -> out_valid=1, out_data=16'hF00F exactly 3 cycles later.
REQ-032 Stream 16'h0001..16'h0006 back-to-back, out_ready=1 -> outputs 0001..0006 consecutively, no gaps, in_ready held at 1.
REQ-033 out_ready=0, push 16'h00F0, 16'hF000, 16'h0F00, then a 4th -> in_ready=0 after 3 words, 4th not accepted, count=3. Then out_ready=1 -> words emerge in order.
REQ-034 Full pipe, in_valid=1 and out_ready=1 for 4 cycles -> one in and one out per cycle, count stays 3.
REQ-035 Two words in flight, pulse flush for 1 cycle -> out_valid=0 next cycle, count=0, flushed words never appear.
REQ-036 reset=0 asserted mid-stream for one edge -> all outputs at reset values next cycle; in_ready=1 after reset=1.
